key_ctrl: RTL and testbench

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl.sv | 163 ++++++++++++++++
 tb/tb_key_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_ctrl.sv
// Key-driven control of run/gate/page for a frequency meter: press, long-press and release handling.
// Optional auto-repeat of held up/down keys is enabled by defining KEY_CTRL_REPEAT_EN.
module key_ctrl #(
    parameter int unsigned p_system_clk = 100_000_000,
    parameter int unsigned p_long_ms    = 1000,
    parameter int unsigned p_repeat_ms  = 200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_key_val,
    input  logic [4:0] i_key,
    output logic       o_run,
    output logic [1:0] o_gate_sel,
    output logic [1:0] o_page,
    output logic       o_clr
);

    localparam int unsigned TICK_CYC = p_system_clk / 1000;
    localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYC - 1);
    localparam logic [9:0] LONG_MS   = 10'(p_long_ms);
    localparam logic [9:0] REPEAT_MS = 10'(p_repeat_ms);

    localparam logic [4:0] K_RUN   = 5'b00001;
    localparam logic [4:0] K_UP    = 5'b00010;
    localparam logic [4:0] K_DOWN  = 5'b00100;
    localparam logic [4:0] K_LEFT  = 5'b01000;
    localparam logic [4:0] K_RIGHT = 5'b10000;

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_LONG, S_REPEAT} state_t;

    state_t        r_state;
    logic [4:0]    r_key_prev;
    logic [4:0]    r_trk;
    logic [PW-1:0] r_presc;
    logic [9:0]    r_ms_cnt;

    logic [4:0] w_press;
    logic [4:0] w_first;
    logic       w_rel;
    logic       w_tick;
    logic [9:0] w_ms_lim;
    logic       w_ms_hit;
    logic [1:0] w_gate_new;

    function automatic logic [1:0] f_gate_step(input logic [4:0] key, input logic [1:0] gate);
        if (key == K_UP)
            return (gate == 2'd3) ? gate : gate + 2'd1;
        else if (key == K_DOWN)
            return (gate == 2'd0) ? gate : gate - 2'd1;
        else
            return gate;
    endfunction

    // Lowest-index new press wins; two's-complement isolates the lowest set bit.
    assign w_press    = i_key & ~r_key_prev;
    assign w_first    = w_press & (~w_press + 5'd1);
    assign w_rel      = i_key_val && ((r_trk & ~i_key) != '0);
    assign w_tick     = (r_presc == TICK_LAST);
    assign w_ms_lim   = (r_state == S_REPEAT) ? REPEAT_MS : LONG_MS;
    assign w_ms_hit   = (r_ms_cnt >= w_ms_lim);
    assign w_gate_new = f_gate_step(w_first, o_gate_sel);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_key_prev <= '0;
            r_trk      <= '0;
            r_presc    <= '0;
            r_ms_cnt   <= '0;
            o_run      <= 1'b1;
            o_gate_sel <= 2'd2;
            o_page     <= 2'd0;
            o_clr      <= 1'b0;
        end else begin
            o_clr <= 1'b0;
            if (i_key_val)
                r_key_prev <= i_key;

            if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (r_ms_cnt != '1)
                        r_ms_cnt <= r_ms_cnt + 10'd1;
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (i_key_val && (w_press != '0)) begin
                        r_trk    <= w_first;
                        r_presc  <= '0;
                        r_ms_cnt <= '0;
                        r_state  <= S_PRESS;
                        if (w_first == K_UP || w_first == K_DOWN) begin
                            o_gate_sel <= w_gate_new;
                            o_clr      <= (w_gate_new != o_gate_sel);
                        end else if (w_first == K_LEFT) begin
                            o_page <= (o_page == 2'd0) ? 2'd2 : o_page - 2'd1;
                        end else if (w_first == K_RIGHT) begin
                            o_page <= (o_page >= 2'd2) ? 2'd0 : o_page + 2'd1;
                        end
                    end
                end
                S_PRESS: begin
                    if (w_rel) begin
                        if (r_trk == K_RUN) begin
                            o_run <= ~o_run;
                            o_clr <= 1'b1;
                        end
                        r_trk   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_ms_hit) begin
                        if (r_trk == K_RUN) begin
                            o_gate_sel <= 2'd2;
                            o_page     <= 2'd0;
                            o_run      <= 1'b1;
                            o_clr      <= 1'b1;
                            r_state    <= S_LONG;
                        end else if (r_trk == K_UP || r_trk == K_DOWN) begin
`ifdef KEY_CTRL_REPEAT_EN
                            // The long-press threshold delivers the first repeat.
                            o_gate_sel <= f_gate_step(r_trk, o_gate_sel);
                            o_clr      <= (f_gate_step(r_trk, o_gate_sel) != o_gate_sel);
                            r_ms_cnt   <= '0;
                            r_state    <= S_REPEAT;
`else
                            r_state    <= S_LONG;
`endif
                        end else begin
                            r_state <= S_LONG;
                        end
                    end
                end
                S_LONG: begin
                    if (w_rel) begin
                        r_trk   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_REPEAT: begin
`ifdef KEY_CTRL_REPEAT_EN
                    if (w_rel) begin
                        r_trk   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_ms_hit) begin
                        o_gate_sel <= f_gate_step(r_trk, o_gate_sel);
                        o_clr      <= (f_gate_step(r_trk, o_gate_sel) != o_gate_sel);
                        r_ms_cnt   <= '0;
                    end
`else
                    r_trk   <= '0;
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl: directed scenarios plus randomized key sequences against a
// time-based reference model. Honours KEY_CTRL_REPEAT_EN in the model.
module tb_key_ctrl;

    localparam int TICK = 100;
    localparam int LONG = 10;
    localparam int REP  = 2;
`ifdef KEY_CTRL_REPEAT_EN
    localparam int REPEAT_ON = 1;
`else
    localparam int REPEAT_ON = 0;
`endif

    logic       clk;
    logic       rstn;
    logic       i_key_val;
    logic [4:0] i_key;
    logic       o_run;
    logic [1:0] o_gate_sel;
    logic [1:0] o_page;
    logic       o_clr;

    key_ctrl #(
        .p_system_clk(100_000),
        .p_long_ms   (LONG),
        .p_repeat_ms (REP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_key_val (i_key_val),
        .i_key     (i_key),
        .o_run     (o_run),
        .o_gate_sel(o_gate_sel),
        .o_page    (o_page),
        .o_clr     (o_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          now = 0;
    int          clr_seen = 0;

    // Reference model: outputs, previous snapshot, tracked key index and time of its press.
    int         m_gate, m_page, m_run, m_clr;
    logic [4:0] m_prev;
    int         m_trk, m_ts, m_done;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        now++;
        if (o_clr) clr_seen++;
    endtask

    task automatic wait_to(input int t);
        while (now < t) step();
    endtask

    task automatic m_reset();
        m_gate = 2; m_page = 0; m_run = 1; m_clr = 0;
        m_prev = '0; m_trk = -1; m_ts = 0; m_done = 0;
    endtask

    task automatic m_gate_step(input int idx);
        int g;
        g = m_gate;
        if (idx == 1 && m_gate < 3) g = m_gate + 1;
        if (idx == 2 && m_gate > 0) g = m_gate - 1;
        if (g != m_gate) m_clr++;
        m_gate = g;
    endtask

    // Apply every long-press / repeat action whose time has come by 'now'.
    task automatic m_advance();
        int elapsed, target;
        if (m_trk >= 0) begin
            elapsed = (now - m_ts) / TICK;
            if (elapsed >= LONG) begin
                target = 1;
                if (REPEAT_ON != 0 && (m_trk == 1 || m_trk == 2))
                    target = 1 + (elapsed - LONG) / REP;
                while (m_done < target) begin
                    if (m_done == 0 && m_trk == 0) begin
                        m_gate = 2; m_page = 0; m_run = 1; m_clr++;
                    end else if (m_trk == 1 || m_trk == 2) begin
                        if (REPEAT_ON != 0) m_gate_step(m_trk);
                    end
                    m_done++;
                end
            end
        end
    endtask

    task automatic m_strobe(input logic [4:0] k);
        logic [4:0] press;
        int idx;
        m_advance();
        press = k & ~m_prev;
        if (m_trk < 0) begin
            if (press != '0) begin
                idx = -1;
                for (int i = 4; i >= 0; i--) if (press[i]) idx = i;
                m_trk = idx; m_ts = now; m_done = 0;
                case (idx)
                    1, 2: m_gate_step(idx);
                    3: m_page = (m_page == 0) ? 2 : m_page - 1;
                    4: m_page = (m_page == 2) ? 0 : m_page + 1;
                    default: ;
                endcase
            end
        end else if (k[m_trk] == 1'b0) begin
            if (m_trk == 0 && m_done == 0) begin
                m_run = 1 - m_run; m_clr++;
            end
            m_trk = -1;
        end
        m_prev = k;
    endtask

    task automatic strobe(input logic [4:0] k);
        i_key = k;
        i_key_val = 1'b1;
        step();
        i_key_val = 1'b0;
        m_strobe(k);
    endtask

    task automatic wait_ms(input int ms);
        wait_to(m_ts + ms * TICK + TICK / 2);
    endtask

    task automatic check_all(input string tag);
        m_advance();
        check_eq({tag, ".gate"}, int'(o_gate_sel), m_gate);
        check_eq({tag, ".page"}, int'(o_page), m_page);
        check_eq({tag, ".run"}, int'(o_run), m_run);
        check_eq({tag, ".clr"}, clr_seen, m_clr);
        clr_seen = 0;
        m_clr = 0;
    endtask

    task automatic tap(input logic [4:0] k, input string tag);
        strobe(k);
        check_all(tag);
        strobe(5'b00000);
        check_all({tag, ".rel"});
    endtask

    initial begin
        int ms;
        logic [4:0] k;
        rstn = 1'b0; i_key_val = 1'b0; i_key = '0;
        m_reset();
        repeat (3) step();
        check_eq("reset.clr_level", int'(o_clr), 0);
        check_all("reset");
        rstn = 1'b1;
        step();

        // Up from gate 2, then a saturated up press.
        tap(5'b00010, "up1");
        check_eq("up1.const", int'(o_gate_sel), 3);
        tap(5'b00010, "up_sat");
        check_eq("up_sat.const", int'(o_gate_sel), 3);

        // Page wrap: left from 0, then right three times.
        tap(5'b01000, "left");
        check_eq("left.const", int'(o_page), 2);
        for (int i = 0; i < 3; i++) tap(5'b10000, "right");
        check_eq("right.const", int'(o_page), 2);

        // Short run press toggles on release.
        strobe(5'b00001);
        wait_ms(5);
        strobe(5'b00000);
        check_all("run_short");
        check_eq("run_short.const", int'(o_run), 0);

        // Long run press forces gate=2, page=0, run=1; release does nothing more.
        for (int i = 0; i < 3; i++) tap(5'b00100, "down_to0");
        tap(5'b10000, "pg0");
        tap(5'b10000, "pg1");
        strobe(5'b00001);
        wait_ms(LONG);
        check_all("run_long");
        check_eq("run_long.gate", int'(o_gate_sel), 2);
        check_eq("run_long.run", int'(o_run), 1);
        strobe(5'b00000);
        check_all("run_long.rel");

        // Held up key: repeats when enabled, single action otherwise.
        tap(5'b00100, "dn_a");
        tap(5'b00100, "dn_b");
        tap(5'b00100, "dn_sat");
        strobe(5'b00010);
        check_all("hold.press");
        check_eq("hold.press.const", int'(o_gate_sel), 1);
        wait_ms(12);
        check_all("hold.12ms");
        check_eq("hold.12ms.const", int'(o_gate_sel), (REPEAT_ON != 0) ? 3 : 1);
        wait_ms(14);
        check_all("hold.14ms");
        strobe(5'b00000);
        check_all("hold.rel");

        // Simultaneous up+down: only up acts; down never acts later.
        for (int i = 0; i < 3; i++) tap(5'b00100, "dn_clr");
        strobe(5'b00110);
        check_all("both");
        check_eq("both.const", int'(o_gate_sel), 1);
        strobe(5'b00100);
        check_all("both.up_rel");
        strobe(5'b00000);
        check_all("both.idle");
        tap(5'b00100, "dn_after");
        check_eq("dn_after.const", int'(o_gate_sel), 0);

        // Reset mid-press aborts; a still-held key is a new press afterwards.
        strobe(5'b00001);
        wait_ms(5);
        rstn = 1'b0;
        step(); step();
        m_reset();
        clr_seen = 0;
        check_all("rst_mid");
        rstn = 1'b1;
        step();
        strobe(5'b00001);
        wait_ms(3);
        strobe(5'b00000);
        check_all("rst_mid.run");

        // Randomized key sequences.
        for (int it = 0; it < 25; it++) begin
            strobe(5'($urandom_range(1, 31)));
            check_all("rnd.press");
            if (m_trk >= 0) begin
                ms = 0;
                for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
                    ms += $urandom_range(1, 5);
                    wait_ms(ms);
                    k = 5'($urandom_range(0, 31));
                    k[m_trk] = 1'b1;
                    strobe(k);
                    check_all("rnd.noise");
                end
                ms += $urandom_range(1, 5);
                wait_ms(ms);
                k = 5'($urandom_range(0, 31));
                k[m_trk] = 1'b0;
                strobe(k);
                check_all("rnd.rel");
            end
            if ($urandom_range(0, 1) == 0) begin
                strobe(5'b00000);
                check_all("rnd.clear");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
